// File: rtl/td4_sequencer.sv
// TD4 control sequencer: fetches one instruction byte per step over a ROM
// request/valid handshake, decodes it into datapath strobes and drives PC control.
module td4_sequencer #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] ROM_DATA,
  input  logic       ROM_VALID,
  output logic       ROM_REQ,
  input  logic       ALU_CARRY,
  output logic [1:0] SEL,
  output logic [3:0] IMM,
  output logic       LD_A,
  output logic       LD_B,
  output logic       LD_OUT,
  output logic       PC_EN,
  output logic       PC_LOAD,
  output logic [3:0] PC_IN,
  output logic       CFLAG,
  output logic       ILLEGAL,
  output logic       FAULT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam bit         timeout_on = (TIMEOUT != 0);
  localparam logic [7:0] last_wait  = timeout_on ? 8'(TIMEOUT - 1) : 8'd0;

  state_t     state_reg, state_next;
  logic [7:0] ir_reg, ir_next;
  logic [7:0] wait_reg, wait_next;
  logic       cflag_reg, cflag_next;
  logic       illegal_reg, illegal_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= S_IDLE;
      ir_reg      <= '0;
      wait_reg    <= '0;
      cflag_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ir_reg      <= ir_next;
      wait_reg    <= wait_next;
      cflag_reg   <= cflag_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ir_next      = ir_reg;
    wait_next    = wait_reg;
    cflag_next   = cflag_reg;
    illegal_next = illegal_reg;
    ROM_REQ      = 1'b0;
    SEL          = 2'b11;
    IMM          = 4'd0;
    LD_A         = 1'b0;
    LD_B         = 1'b0;
    LD_OUT       = 1'b0;
    PC_EN        = 1'b0;
    PC_LOAD      = 1'b1;

    case (state_reg)
      S_IDLE: begin
        state_next = S_FETCH;
        wait_next  = '0;
      end

      S_FETCH: begin
        ROM_REQ = 1'b1;
        // A valid on the last permitted wait cycle still wins over the timeout.
        if (ROM_VALID) begin
          ir_next    = ROM_DATA;
          state_next = S_EXEC;
        end else if (timeout_on && (wait_reg == last_wait)) begin
          state_next = S_FAULT;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end

      S_EXEC: begin
        PC_EN      = 1'b1;
        IMM        = ir_reg[3:0];
        cflag_next = ALU_CARRY;
        state_next = S_FETCH;
        wait_next  = '0;
        case (ir_reg[7:4])
          4'b0000: begin SEL = 2'b00; LD_A = 1'b1; end
          4'b0101: begin SEL = 2'b01; LD_B = 1'b1; end
          4'b0011: begin SEL = 2'b11; LD_A = 1'b1; end
          4'b0111: begin SEL = 2'b11; LD_B = 1'b1; end
          4'b0001: begin SEL = 2'b01; IMM = 4'd0; LD_A = 1'b1; end
          4'b0100: begin SEL = 2'b00; IMM = 4'd0; LD_B = 1'b1; end
          4'b0010: begin SEL = 2'b10; IMM = 4'd0; LD_A = 1'b1; end
          4'b0110: begin SEL = 2'b10; IMM = 4'd0; LD_B = 1'b1; end
          4'b1001: begin SEL = 2'b01; IMM = 4'd0; LD_OUT = 1'b1; end
          4'b1011: begin SEL = 2'b11; LD_OUT = 1'b1; end
          4'b1111: begin SEL = 2'b11; PC_LOAD = 1'b0; end
          // JNC looks at the carry of the previous instruction.
          4'b1110: begin SEL = 2'b11; PC_LOAD = cflag_reg; end
          default: begin SEL = 2'b11; illegal_next = 1'b1; end
        endcase
      end

      default: begin
        state_next = S_FAULT;
      end
    endcase
  end

  assign PC_IN   = ir_reg[3:0];
  assign CFLAG   = cflag_reg;
  assign ILLEGAL = illegal_reg;
  assign FAULT   = (state_reg == S_FAULT);

endmodule

// File: tb/tb_td4_sequencer.sv
// Directed bench for td4_sequencer: decode table plus reset, handshake,
// timeout, illegal-opcode and reset-during-EXEC sequences.
module tb_td4_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] ROM_DATA = 8'h00;
  logic       ROM_VALID = 1'b0;
  logic       ALU_CARRY = 1'b0;

  logic       ROM_REQ, LD_A, LD_B, LD_OUT, PC_EN, PC_LOAD, CFLAG, ILLEGAL, FAULT;
  logic [1:0] SEL;
  logic [3:0] IMM, PC_IN;

  logic       t4_rom_req, t4_ld_a, t4_ld_b, t4_ld_out, t4_pc_en, t4_pc_load;
  logic       t4_cflag, t4_illegal, t4_fault;
  logic [1:0] t4_sel;
  logic [3:0] t4_imm, t4_pc_in;

  td4_sequencer #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .ROM_DATA(ROM_DATA), .ROM_VALID(ROM_VALID),
    .ROM_REQ(ROM_REQ), .ALU_CARRY(ALU_CARRY), .SEL(SEL), .IMM(IMM),
    .LD_A(LD_A), .LD_B(LD_B), .LD_OUT(LD_OUT), .PC_EN(PC_EN),
    .PC_LOAD(PC_LOAD), .PC_IN(PC_IN), .CFLAG(CFLAG), .ILLEGAL(ILLEGAL),
    .FAULT(FAULT)
  );

  td4_sequencer #(.TIMEOUT(4)) dut_t4 (
    .CLK(CLK), .RST(RST), .ROM_DATA(ROM_DATA), .ROM_VALID(ROM_VALID),
    .ROM_REQ(t4_rom_req), .ALU_CARRY(ALU_CARRY), .SEL(t4_sel), .IMM(t4_imm),
    .LD_A(t4_ld_a), .LD_B(t4_ld_b), .LD_OUT(t4_ld_out), .PC_EN(t4_pc_en),
    .PC_LOAD(t4_pc_load), .PC_IN(t4_pc_in), .CFLAG(t4_cflag),
    .ILLEGAL(t4_illegal), .FAULT(t4_fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic [1:0] sel;
    logic [3:0] imm;
    logic [2:0] ld;      // {LD_A, LD_B, LD_OUT}
    logic       pc_load;
    logic [3:0] pc_in;
    logic       cflag;   // flag seen during this EXEC
  } vec_t;

  vec_t vecs[13];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   req_cnt;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Called at a negedge in FETCH; returns at a negedge in the next FETCH.
  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    ROM_DATA  = v.data;
    ROM_VALID = 1'b1;
    step();
    ROM_VALID = 1'b0;
    ALU_CARRY = v.carry;
    chk($sformatf("v%0d rom_req", idx), {7'd0, ROM_REQ}, 8'd0);
    chk($sformatf("v%0d sel", idx), {6'd0, SEL}, {6'd0, v.sel});
    chk($sformatf("v%0d imm", idx), {4'd0, IMM}, {4'd0, v.imm});
    chk($sformatf("v%0d ld", idx), {5'd0, LD_A, LD_B, LD_OUT}, {5'd0, v.ld});
    chk($sformatf("v%0d pc_en", idx), {7'd0, PC_EN}, 8'd1);
    chk($sformatf("v%0d pc_load", idx), {7'd0, PC_LOAD}, {7'd0, v.pc_load});
    chk($sformatf("v%0d pc_in", idx), {4'd0, PC_IN}, {4'd0, v.pc_in});
    chk($sformatf("v%0d cflag", idx), {7'd0, CFLAG}, {7'd0, v.cflag});
    step();
    chk($sformatf("v%0d back_fetch", idx), {7'd0, ROM_REQ}, 8'd1);
    chk($sformatf("v%0d pc_en_fetch", idx), {7'd0, PC_EN}, 8'd0);
    $display("vec %0d: data=0x%02h sel=%0d imm=0x%0h ld=%03b pc_load=%0b", idx, v.data, SEL, IMM, v.ld, v.pc_load);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ROM_VALID = 1'b1;
    step(); step(); step();
    chk("rst rom_req", {7'd0, ROM_REQ}, 8'd0);
    chk("rst pc_load", {7'd0, PC_LOAD}, 8'd1);
    chk("rst pc_en", {7'd0, PC_EN}, 8'd0);
    chk("rst cflag", {7'd0, CFLAG}, 8'd0);
    chk("rst illegal", {7'd0, ILLEGAL}, 8'd0);
    chk("rst fault", {6'd0, t4_fault, FAULT}, 8'd0);
    chk("rst sel", {6'd0, SEL}, 8'd3);
    chk("rst imm_pcin", {IMM, PC_IN}, 8'd0);
    chk("rst ld", {5'd0, LD_A, LD_B, LD_OUT}, 8'd0);
    RST = 1'b0;
    ROM_VALID = 1'b0;
    chk("idle rom_req", {7'd0, ROM_REQ}, 8'd0);
    step();
    chk("first rom_req", {7'd0, ROM_REQ}, 8'd1);
    $display("reset done: ROM_REQ=%0b", ROM_REQ);
  endtask

  initial begin
    vecs[0]  = '{8'h33, 1'b0, 2'd3, 4'h3, 3'b100, 1'b1, 4'h3, 1'b0};
    vecs[1]  = '{8'h0F, 1'b1, 2'd0, 4'hF, 3'b100, 1'b1, 4'hF, 1'b0};
    vecs[2]  = '{8'hE5, 1'b0, 2'd3, 4'h5, 3'b000, 1'b1, 4'h5, 1'b1};
    vecs[3]  = '{8'hE5, 1'b0, 2'd3, 4'h5, 3'b000, 1'b0, 4'h5, 1'b0};
    vecs[4]  = '{8'h5A, 1'b1, 2'd1, 4'hA, 3'b010, 1'b1, 4'hA, 1'b0};
    vecs[5]  = '{8'h77, 1'b0, 2'd3, 4'h7, 3'b010, 1'b1, 4'h7, 1'b1};
    vecs[6]  = '{8'h19, 1'b0, 2'd1, 4'h0, 3'b100, 1'b1, 4'h9, 1'b0};
    vecs[7]  = '{8'h4C, 1'b0, 2'd0, 4'h0, 3'b010, 1'b1, 4'hC, 1'b0};
    vecs[8]  = '{8'h2E, 1'b0, 2'd2, 4'h0, 3'b100, 1'b1, 4'hE, 1'b0};
    vecs[9]  = '{8'h63, 1'b0, 2'd2, 4'h0, 3'b010, 1'b1, 4'h3, 1'b0};
    vecs[10] = '{8'h95, 1'b0, 2'd1, 4'h0, 3'b001, 1'b1, 4'h5, 1'b0};
    vecs[11] = '{8'hBD, 1'b0, 2'd3, 4'hD, 3'b001, 1'b1, 4'hD, 1'b0};
    vecs[12] = '{8'hF0, 1'b0, 2'd3, 4'h0, 3'b000, 1'b0, 4'h0, 1'b0};

    @(negedge CLK);
    do_reset();

    for (int i = 0; i < 13; i++) run_vec(i);
    chk("no illegal", {7'd0, ILLEGAL}, 8'd0);

    // Illegal opcode: NOP-like, PC advances, sticky flag afterwards.
    ROM_DATA = 8'h80; ROM_VALID = 1'b1;
    step();
    ROM_VALID = 1'b0;
    chk("ill ld", {5'd0, LD_A, LD_B, LD_OUT}, 8'd0);
    chk("ill pc_en", {7'd0, PC_EN}, 8'd1);
    chk("ill pc_load", {7'd0, PC_LOAD}, 8'd1);
    chk("ill sel", {6'd0, SEL}, 8'd3);
    step();
    chk("ill flag", {7'd0, ILLEGAL}, 8'd1);
    $display("illegal 0x80: ILLEGAL=%0b", ILLEGAL);
    run_vec(0);
    chk("ill sticky", {7'd0, ILLEGAL}, 8'd1);

    // Reset asserted during a JMP EXEC.
    ROM_DATA = 8'hF7; ROM_VALID = 1'b1;
    step();
    ROM_VALID = 1'b0;
    chk("jmp pc_load", {7'd0, PC_LOAD}, 8'd0);
    chk("jmp pc_in", {4'd0, PC_IN}, 8'd7);
    RST = 1'b1;
    step();
    chk("rstx pc_en", {7'd0, PC_EN}, 8'd0);
    chk("rstx illegal", {7'd0, ILLEGAL}, 8'd0);
    chk("rstx pc_load", {7'd0, PC_LOAD}, 8'd1);
    chk("rstx rom_req", {7'd0, ROM_REQ}, 8'd0);
    RST = 1'b0;
    step();
    chk("rstx refetch", {7'd0, ROM_REQ}, 8'd1);
    $display("reset mid-EXEC: PC_EN=%0b ILLEGAL=%0b", PC_EN, ILLEGAL);

    // Valid after 3 wait cycles: accepted on the 4th, also for the TIMEOUT=4 copy.
    req_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (ROM_REQ) req_cnt++;
      if (c == 3) begin
        ROM_DATA = 8'h33;
        ROM_VALID = 1'b1;
      end
      if (c < 3) step();
    end
    step();
    ROM_VALID = 1'b0;
    chk("lat req_cycles", 8'(req_cnt), 8'd4);
    chk("lat exec ld_a", {7'd0, LD_A}, 8'd1);
    chk("lat rom_req", {7'd0, ROM_REQ}, 8'd0);
    chk("lat faults", {6'd0, t4_fault, FAULT}, 8'd0);
    chk("lat t4 exec", {7'd0, t4_ld_a}, 8'd1);
    step();
    $display("rom latency 3: ROM_REQ cycles=%0d FAULT=%0b", req_cnt, FAULT);

    // Timeout: the TIMEOUT=4 copy faults after 4 waits, the TIMEOUT=8 copy after 8.
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to4 wait%0d", c), {6'd0, t4_rom_req, t4_fault}, 8'b10);
      step();
    end
    chk("to4 fault", {7'd0, t4_fault}, 8'd1);
    chk("to4 req_en", {6'd0, t4_rom_req, t4_pc_en}, 8'd0);
    for (int c = 4; c < 8; c++) begin
      chk($sformatf("to8 wait%0d", c), {6'd0, ROM_REQ, FAULT}, 8'b10);
      step();
    end
    chk("to8 fault", {7'd0, FAULT}, 8'd1);
    ROM_DATA = 8'h33; ROM_VALID = 1'b1;
    step(); step();
    ROM_VALID = 1'b0;
    chk("fault hold", {4'd0, t4_fault, FAULT, t4_pc_en, PC_EN}, 8'b1100);
    chk("fault no req", {6'd0, t4_rom_req, ROM_REQ}, 8'd0);
    chk("fault no ld", {5'd0, LD_A, LD_B, LD_OUT}, 8'd0);
    $display("timeout: t4 FAULT=%0b t8 FAULT=%0b", t4_fault, FAULT);

    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
